// File: rtl/instr_scheduler.sv
// instr_scheduler: host instruction FIFO plus launch/feed/drain sequencer for the accelerator controller
module instr_scheduler #(
  parameter int INSTR_SIZE = 32,
  parameter int DEPTH      = 16,
  parameter int CW         = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_valid,
  input  logic [INSTR_SIZE-1:0] host_instr,
  output logic                  host_ready,
  input  logic                  go,
  output logic                  acc_start,
  output logic                  instr_valid,
  output logic [INSTR_SIZE-1:0] instr,
  input  logic                  acc_rd_nxt,
  input  logic                  acc_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic [CW-1:0]         fifo_count,
  output logic [CW-1:0]         issued
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LAUNCH, FEED, DRAIN, DONE} state_t;
  state_t state, next;
  logic [INSTR_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, remaining;
  logic drain_seen, push, pop, go_idle;
  assign host_ready  = count < CW'(DEPTH);
  assign push        = host_valid && host_ready;
  assign instr_valid = state == FEED && remaining != '0;
  assign pop         = instr_valid && acc_rd_nxt;
  assign instr       = mem[rptr];
  assign acc_start   = state == LAUNCH;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign fifo_count  = count;
  assign go_idle     = state == IDLE && go;
  // storage needs no reset: the pointers alone decide which entries are live
  always_ff @(posedge clk)
    if (push) mem[wptr] <= host_instr;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next-state: FEED leaves on the pop of the last word; DRAIN ignores ready on its first cycle
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !go ? IDLE : (count != '0 ? LAUNCH : DONE);
      LAUNCH:  next = FEED;
      FEED:    next = (remaining == '0 || (pop && remaining == CW'(1))) ? DRAIN : FEED;
      DRAIN:   next = drain_seen && acc_ready ? DONE : DRAIN;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // program bookkeeping: length snapshot at go, issue count and sticky underrun
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      remaining  <= '0;
      issued     <= '0;
      underrun   <= 1'b0;
      drain_seen <= 1'b0;
    end else begin
      drain_seen <= state == DRAIN;
      if (go_idle) begin
        remaining <= count;
        issued    <= '0;
        underrun  <= 1'b0;
      end else if (pop) begin
        remaining <= remaining - 1'b1;
        issued    <= issued + 1'b1;
      end
      if (state == FEED && acc_rd_nxt && !instr_valid) underrun <= 1'b1;
    end
endmodule

// File: tb/tb_instr_scheduler.sv
// tb_instr_scheduler: randomized scenarios checked against a queue model of the program FIFO
module tb_instr_scheduler;
  localparam int W = 32, D = 16, CW = $clog2(D+1);
  logic clk = 1'b0, rst = 1'b1, host_valid = 1'b0, go = 1'b0, acc_rd_nxt = 1'b0, acc_ready = 1'b0;
  logic [W-1:0] host_instr = '0;
  logic host_ready, acc_start, instr_valid, busy, done, underrun;
  logic [W-1:0] instr;
  logic [CW-1:0] fifo_count, issued;
  int checks = 0, failures = 0, last_issued = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  instr_scheduler #(.INSTR_SIZE(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_instr(host_instr), .host_ready(host_ready),
    .go(go), .acc_start(acc_start), .instr_valid(instr_valid), .instr(instr), .acc_rd_nxt(acc_rd_nxt),
    .acc_ready(acc_ready), .busy(busy), .done(done), .underrun(underrun), .fifo_count(fifo_count),
    .issued(issued)
  );

  // idle-time pushes; the model accepts only while it holds fewer than D words
  task automatic push_words(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      host_valid = 1'b1;
      host_instr = $urandom;
      checks++;
      if (host_ready !== (q.size() < D)) begin
        failures++;
        $display("FAIL %s host_ready: got %b expected %b", tag, host_ready, q.size() < D);
      end
      checks++;
      if (fifo_count !== CW'(q.size())) begin
        failures++;
        $display("FAIL %s fifo_count: got %0d expected %0d", tag, fifo_count, q.size());
      end
      if (q.size() < D) q.push_back(host_instr);
      @(negedge clk);
    end
    host_valid = 1'b0;
  endtask

  // issues go and runs one program; rdy_from<0 means random acc_ready, else ready from that cycle on
  task automatic run_program(input bit rnd, input int rdy_from, input int extra,
                             input int lat_lo, input int lat_hi, input string tag);
    int n, pops, starts, start_cyc, lat, pushed;
    bit can_push;
    n = q.size(); pops = 0; starts = 0; start_cyc = 0; lat = 0; pushed = 0;
    go = 1'b1; acc_rd_nxt = 1'b0; host_valid = 1'b0;
    @(negedge clk);
    go = 1'b0;
    for (int cyc = 1; cyc < 400 && lat == 0; cyc++) begin
      acc_rd_nxt = rnd ? 1'($urandom) : 1'b1;
      acc_ready  = rdy_from < 0 ? 1'($urandom) : (cyc >= rdy_from);
      host_valid = pushed < extra;
      host_instr = $urandom;
      can_push   = q.size() < D;
      checks++;
      if (fifo_count !== CW'(q.size()) || host_ready !== can_push) begin
        failures++;
        $display("FAIL %s occupancy cyc=%0d: count=%0d ready=%b expected count=%0d ready=%b",
                 tag, cyc, fifo_count, host_ready, q.size(), can_push);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy cyc=%0d: got %b expected 1", tag, cyc, busy);
      end
      if (acc_start === 1'b1) begin starts++; start_cyc = cyc; end
      if (done === 1'b1) lat = cyc;
      if (instr_valid === 1'b1) begin
        checks++;
        if (cyc == 1 || pops >= n) begin
          failures++;
          $display("FAIL %s instr_valid cyc=%0d: got 1 expected 0 (pops=%0d of %0d)", tag, cyc, pops, n);
        end else if (acc_rd_nxt) begin
          if (instr !== q[0]) begin
            failures++;
            $display("FAIL %s instr word %0d: got %h expected %h", tag, pops, instr, q[0]);
          end
          void'(q.pop_front());
          pops++;
        end
      end
      if (host_valid && can_push) begin q.push_back(host_instr); pushed++; end
      @(negedge clk);
    end
    acc_rd_nxt = 1'b0; host_valid = 1'b0; acc_ready = 1'b0;
    checks++;
    if (lat < lat_lo || lat > lat_hi) begin
      failures++;
      $display("FAIL %s done latency: got %0d expected %0d..%0d (0 = timeout)", tag, lat, lat_lo, lat_hi);
    end
    checks++;
    if (starts != (n > 0 ? 1 : 0) || (n > 0 && start_cyc != 1)) begin
      failures++;
      $display("FAIL %s acc_start: got %0d pulses at cyc %0d expected %0d at cyc 1", tag, starts, start_cyc, n > 0);
    end
    checks++;
    if (pops != n || issued !== CW'(n)) begin
      failures++;
      $display("FAIL %s issued: pops=%0d issued=%0d expected %0d", tag, pops, issued, n);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0 || fifo_count !== CW'(q.size())) begin
      failures++;
      $display("FAIL %s after done: busy=%b done=%b underrun=%b count=%0d expected 0 0 0 %0d",
               tag, busy, done, underrun, fifo_count, q.size());
    end
    last_issued = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== '0 || host_ready !== 1'b1 || acc_start !== 1'b0 || instr_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0 || issued !== '0) begin
      failures++;
      $display("FAIL reset: count=%0d ready=%b start=%b valid=%b busy=%b done=%b underrun=%b issued=%0d expected 0 1 0 0 0 0 0 0",
               fifo_count, host_ready, acc_start, instr_valid, busy, done, underrun, issued);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    push_words(3, "basic_push");
    run_program(1'b0, 0, 0, 7, 7, "basic");
    push_words(1, "min_push");
    run_program(1'b0, 0, 0, 5, 5, "min_latency");
  endtask

  task automatic test_stale_ready();
    push_words(1, "stale_push");
    run_program(1'b0, 9, 0, 10, 10, "late_ready");
    push_words(2, "stale_push2");
    run_program(1'b0, 6, 0, 7, 7, "ready_second_drain");
  endtask

  task automatic test_empty();
    run_program(1'b0, 0, 0, 1, 2, "empty");
  endtask

  task automatic test_full();
    push_words(17, "fill");
    checks++;
    if (fifo_count !== CW'(D) || host_ready !== 1'b0) begin
      failures++;
      $display("FAIL full: count=%0d ready=%b expected %0d 0", fifo_count, host_ready, D);
    end
    run_program(1'b0, 0, 20, 20, 20, "full_push_pop");
    run_program(1'b1, -1, 0, 1, 400, "wrap_order");
  endtask

  task automatic test_push_during_feed();
    push_words(2, "feed_push");
    run_program(1'b1, -1, 2, 1, 400, "feed_extra");
    checks++;
    if (fifo_count !== CW'(2)) begin
      failures++;
      $display("FAIL feed_extra leftover: got %0d expected 2", fifo_count);
    end
    run_program(1'b1, -1, 0, 1, 400, "feed_second");
  endtask

  task automatic test_idle_rd_nxt();
    push_words(2, "idle_push");
    acc_rd_nxt = 1'b1;
    repeat (3) @(negedge clk);
    acc_rd_nxt = 1'b0;
    checks++;
    if (fifo_count !== CW'(2) || instr_valid !== 1'b0 || issued !== CW'(last_issued) || underrun !== 1'b0) begin
      failures++;
      $display("FAIL idle_rd_nxt: count=%0d valid=%b issued=%0d underrun=%b expected 2 0 %0d 0",
               fifo_count, instr_valid, issued, underrun, last_issued);
    end
    run_program(1'b0, 0, 0, 6, 6, "idle_rd_drain");
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 5; p++) begin
      push_words($urandom_range(0, D), "b2b_push");
      run_program(1'b1, -1, $urandom_range(0, 3), 1, 400, "b2b");
    end
  endtask

  task automatic test_reset_mid();
    push_words(4, "rstmid_push");
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    acc_rd_nxt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    acc_rd_nxt = 1'b0;
    checks++;
    if (issued !== CW'(1) || instr_valid !== 1'b1 || fifo_count !== CW'(3)) begin
      failures++;
      $display("FAIL rstmid before: issued=%0d valid=%b count=%0d expected 1 1 3", issued, instr_valid, fifo_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_count !== '0 || instr_valid !== 1'b0 || acc_start !== 1'b0 || issued !== '0) begin
      failures++;
      $display("FAIL rstmid after: busy=%b count=%0d valid=%b start=%b issued=%0d expected 0 0 0 0 0",
               busy, fifo_count, instr_valid, acc_start, issued);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_words(2, "rstmid_push2");
    run_program(1'b0, 0, 0, 6, 6, "rstmid_rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_ready();
    test_empty();
    test_full();
    test_push_during_feed();
    test_idle_rd_nxt();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
